scalar_rs: RTL and testbench

//   Reservation station directly upstream of the scalar ALU. Buffers dispatched

---
 rtl/scalar_rs_pkg.sv | 62 ++++++
 rtl/scalar_rs_lowest_select.sv | 31 +++
 rtl/scalar_rs.sv | 224 ++++++++++++++++++++++
 tb/tb_scalar_rs.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scalar_rs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scalar_rs_pkg
// Purpose  : Shared widths, entry record and CDB snoop helper for the scalar
//            ALU reservation station.
// Contents : RS_SIZE_BIT_DEF / ROB_WIDTH_BIT_DEF / RS_TYPE_BIT_DEF defaults,
//            rs_entry_t entry record, cdb_pick_t and cdb_pick() snoop helper.
// Revision : 1.0  initial release
// ============================================================================
package scalar_rs_pkg;

    localparam int RS_SIZE_BIT_DEF   = 3;
    localparam int ROB_WIDTH_BIT_DEF = 4;
    localparam int RS_TYPE_BIT_DEF   = 5;
    localparam int DATA_W            = 32;

    // One reservation-station slot. hasN=1 means operand N is still waiting
    // for ROB entry qN to broadcast on a CDB.
    typedef struct packed {
        logic                         busy;
        logic [RS_TYPE_BIT_DEF-1:0]   op_type;
        logic [DATA_W-1:0]            v1;
        logic [DATA_W-1:0]            v2;
        logic                         has1;
        logic                         has2;
        logic [ROB_WIDTH_BIT_DEF-1:0] q1;
        logic [ROB_WIDTH_BIT_DEF-1:0] q2;
        logic [ROB_WIDTH_BIT_DEF-1:0] rob_id;
    } rs_entry_t;

    // Result of looking for a producer tag on both CDB buses.
    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] value;
    } cdb_pick_t;

    // ROB ids are unique among in-flight producers, so at most one bus can
    // really match a given tag; ALU is checked first purely for determinism.
    function automatic cdb_pick_t cdb_pick(
        input logic                         alu_ready,
        input logic [ROB_WIDTH_BIT_DEF-1:0] alu_id,
        input logic [DATA_W-1:0]            alu_val,
        input logic                         mem_ready,
        input logic [ROB_WIDTH_BIT_DEF-1:0] mem_id,
        input logic [DATA_W-1:0]            mem_val,
        input logic [ROB_WIDTH_BIT_DEF-1:0] tag
    );
        cdb_pick_t r;
        r.hit   = 1'b0;
        r.value = '0;
        if (alu_ready && (alu_id == tag)) begin
            r.hit   = 1'b1;
            r.value = alu_val;
        end else if (mem_ready && (mem_id == tag)) begin
            r.hit   = 1'b1;
            r.value = mem_val;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scalar_rs_lowest_select.sv
`default_nettype none
// ============================================================================
// Module   : rs_lowest_select
// Purpose  : Priority encoder returning the lowest set request bit.
// Ports    : req_i   [WIDTH]   request vector
//            found_o           any request set
//            idx_o   [IDX_BIT] index of lowest set bit (0 when none)
// Revision : 1.0  initial release
// ============================================================================
module rs_lowest_select #(
    parameter int WIDTH   = 8,
    parameter int IDX_BIT = 3
) (
    input  logic [WIDTH-1:0]   req_i,
    output logic               found_o,
    output logic [IDX_BIT-1:0] idx_o
);

    always_comb begin
        found_o = |req_i;
        idx_o   = '0;
        // Scan downwards so the last (lowest) hit overrides.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_BIT'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/scalar_rs.sv
`default_nettype none
// ============================================================================
// Module   : scalar_rs
// Purpose  : Reservation station feeding the scalar ALU. Buffers dispatched
//            ops, snoops the ALU and MEM CDBs for pending operands, and issues
//            at most one ready entry per cycle as a registered op. Flushed
//            wholesale by clear_in.
// Ports    : clk_in, rst_in (async, active low), rdy_in (global stall),
//            clear_in (flush)
//            inst_*        dispatch request and operand/dependency info
//            full          all entries busy
//            cdb_alu_*     ALU writeback bus
//            cdb_mem_*     LSB writeback bus
//            exe_*         registered issue to scalar_alu
// Revision : 1.0  initial release
// ============================================================================
module scalar_rs
    import scalar_rs_pkg::*;
#(
    parameter int RS_SIZE_BIT    = RS_SIZE_BIT_DEF,
    parameter int ROB_WIDTH_BIT  = ROB_WIDTH_BIT_DEF,   // must equal package width
    parameter int TYPE_BIT       = RS_TYPE_BIT_DEF,     // must equal package width
    parameter bit CHECK_OVERFLOW = 1'b1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,

    input  logic                     inst_valid,
    input  logic [TYPE_BIT-1:0]      inst_type,
    input  logic [31:0]              inst_r1,
    input  logic                     inst_has_dep1,
    input  logic [ROB_WIDTH_BIT-1:0] inst_dep1,
    input  logic [31:0]              inst_r2,
    input  logic                     inst_has_dep2,
    input  logic [ROB_WIDTH_BIT-1:0] inst_dep2,
    input  logic [ROB_WIDTH_BIT-1:0] inst_rob_id,
    output logic                     full,

    input  logic                     cdb_alu_ready,
    input  logic [ROB_WIDTH_BIT-1:0] cdb_alu_rob_id,
    input  logic [31:0]              cdb_alu_value,
    input  logic                     cdb_mem_ready,
    input  logic [ROB_WIDTH_BIT-1:0] cdb_mem_rob_id,
    input  logic [31:0]              cdb_mem_value,

    output logic                     exe_valid,
    output logic [TYPE_BIT-1:0]      exe_type,
    output logic [31:0]              exe_r1,
    output logic [31:0]              exe_r2,
    output logic [ROB_WIDTH_BIT-1:0] exe_rob_id
);

    localparam int RS_SIZE = 1 << RS_SIZE_BIT;

    rs_entry_t entries_q [RS_SIZE];
    rs_entry_t entries_d [RS_SIZE];

    logic                     exe_valid_q,  exe_valid_d;
    logic [TYPE_BIT-1:0]      exe_type_q,   exe_type_d;
    logic [31:0]              exe_r1_q,     exe_r1_d;
    logic [31:0]              exe_r2_q,     exe_r2_d;
    logic [ROB_WIDTH_BIT-1:0] exe_rob_id_q, exe_rob_id_d;

    logic [RS_SIZE-1:0]       w_free_vec;
    logic [RS_SIZE-1:0]       w_ready_vec;
    logic                     w_free_found;
    logic [RS_SIZE_BIT-1:0]   w_free_idx;
    logic                     w_ready_found;
    logic [RS_SIZE_BIT-1:0]   w_ready_idx;

    // Both selections look only at pre-edge state, so the slot being issued
    // this cycle is still busy and can never be chosen as the free slot.
    always_comb begin
        w_free_vec  = '0;
        w_ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_free_vec[i]  = ~entries_q[i].busy;
            w_ready_vec[i] = entries_q[i].busy & ~entries_q[i].has1 & ~entries_q[i].has2;
        end
    end

    assign full = ~|w_free_vec;

    rs_lowest_select #(
        .WIDTH   (RS_SIZE),
        .IDX_BIT (RS_SIZE_BIT)
    ) u_free_sel (
        .req_i   (w_free_vec),
        .found_o (w_free_found),
        .idx_o   (w_free_idx)
    );

    rs_lowest_select #(
        .WIDTH   (RS_SIZE),
        .IDX_BIT (RS_SIZE_BIT)
    ) u_ready_sel (
        .req_i   (w_ready_vec),
        .found_o (w_ready_found),
        .idx_o   (w_ready_idx)
    );

    always_comb begin
        cdb_pick_t p1;
        cdb_pick_t p2;
        rs_entry_t new_e;

        for (int i = 0; i < RS_SIZE; i++) begin
            entries_d[i] = entries_q[i];
        end
        exe_valid_d  = 1'b0;
        exe_type_d   = exe_type_q;
        exe_r1_d     = exe_r1_q;
        exe_r2_d     = exe_r2_q;
        exe_rob_id_d = exe_rob_id_q;
        p1           = '0;
        p2           = '0;
        new_e        = '0;

        // Snoop: each operand independently, so two buses can wake both
        // operands of one entry in the same cycle.
        for (int i = 0; i < RS_SIZE; i++) begin
            if (entries_q[i].busy) begin
                p1 = cdb_pick(cdb_alu_ready, cdb_alu_rob_id, cdb_alu_value,
                              cdb_mem_ready, cdb_mem_rob_id, cdb_mem_value,
                              entries_q[i].q1);
                p2 = cdb_pick(cdb_alu_ready, cdb_alu_rob_id, cdb_alu_value,
                              cdb_mem_ready, cdb_mem_rob_id, cdb_mem_value,
                              entries_q[i].q2);
                if (entries_q[i].has1 && p1.hit) begin
                    entries_d[i].v1   = p1.value;
                    entries_d[i].has1 = 1'b0;
                end
                if (entries_q[i].has2 && p2.hit) begin
                    entries_d[i].v2   = p2.value;
                    entries_d[i].has2 = 1'b0;
                end
            end
        end

        // Issue
        if (w_ready_found) begin
            exe_valid_d                  = 1'b1;
            exe_type_d                   = entries_q[w_ready_idx].op_type;
            exe_r1_d                     = entries_q[w_ready_idx].v1;
            exe_r2_d                     = entries_q[w_ready_idx].v2;
            exe_rob_id_d                 = entries_q[w_ready_idx].rob_id;
            entries_d[w_ready_idx].busy  = 1'b0;
        end

        // Dispatch, with same-cycle CDB bypass for pending operands.
        if (inst_valid && w_free_found) begin
            p1 = cdb_pick(cdb_alu_ready, cdb_alu_rob_id, cdb_alu_value,
                          cdb_mem_ready, cdb_mem_rob_id, cdb_mem_value, inst_dep1);
            p2 = cdb_pick(cdb_alu_ready, cdb_alu_rob_id, cdb_alu_value,
                          cdb_mem_ready, cdb_mem_rob_id, cdb_mem_value, inst_dep2);
            new_e.busy    = 1'b1;
            new_e.op_type = inst_type;
            new_e.rob_id  = inst_rob_id;
            new_e.q1      = inst_dep1;
            new_e.q2      = inst_dep2;
            new_e.has1    = inst_has_dep1 && !p1.hit;
            new_e.has2    = inst_has_dep2 && !p2.hit;
            new_e.v1      = !inst_has_dep1 ? inst_r1 : p1.value;
            new_e.v2      = !inst_has_dep2 ? inst_r2 : p2.value;
            entries_d[w_free_idx] = new_e;
        end

        // Flush overrides everything above, including the dispatch.
        if (clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_d[i].busy = 1'b0;
            end
            exe_valid_d  = 1'b0;
            exe_type_d   = exe_type_q;
            exe_r1_d     = exe_r1_q;
            exe_r2_d     = exe_r2_q;
            exe_rob_id_d = exe_rob_id_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_q[i] <= '0;
            end
            exe_valid_q  <= 1'b0;
            exe_type_q   <= '0;
            exe_r1_q     <= '0;
            exe_r2_q     <= '0;
            exe_rob_id_q <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_q[i] <= entries_d[i];
            end
            exe_valid_q  <= exe_valid_d;
            exe_type_q   <= exe_type_d;
            exe_r1_q     <= exe_r1_d;
            exe_r2_q     <= exe_r2_d;
            exe_rob_id_q <= exe_rob_id_d;
        end
    end

    assign exe_valid  = exe_valid_q;
    assign exe_type   = exe_type_q;
    assign exe_r1     = exe_r1_q;
    assign exe_r2     = exe_r2_q;
    assign exe_rob_id = exe_rob_id_q;

    // A dispatch while full is an upstream protocol violation; it is dropped.
    generate
        if (CHECK_OVERFLOW) begin : g_overflow_chk
            always_ff @(posedge clk_in) begin
                if (rst_in && rdy_in && !clear_in) begin
                    assert (!(inst_valid && full))
                        else $error("scalar_rs: dispatch while full");
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_scalar_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_scalar_rs
// Purpose  : Directed self-checking bench for scalar_rs.
// Revision : 1.0  initial release
// ============================================================================
module tb_scalar_rs;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        clear_in = 1'b0;
    logic        inst_valid = 1'b0;
    logic [4:0]  inst_type = '0;
    logic [31:0] inst_r1 = '0;
    logic        inst_has_dep1 = 1'b0;
    logic [3:0]  inst_dep1 = '0;
    logic [31:0] inst_r2 = '0;
    logic        inst_has_dep2 = 1'b0;
    logic [3:0]  inst_dep2 = '0;
    logic [3:0]  inst_rob_id = '0;
    logic        full;
    logic        cdb_alu_ready = 1'b0;
    logic [3:0]  cdb_alu_rob_id = '0;
    logic [31:0] cdb_alu_value = '0;
    logic        cdb_mem_ready = 1'b0;
    logic [3:0]  cdb_mem_rob_id = '0;
    logic [31:0] cdb_mem_value = '0;
    logic        exe_valid;
    logic [4:0]  exe_type;
    logic [31:0] exe_r1;
    logic [31:0] exe_r2;
    logic [3:0]  exe_rob_id;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk_in = ~clk_in;

    // The overflow scenario below is driven on purpose, so the DUT's
    // protocol assertion is disabled here.
    scalar_rs #(
        .CHECK_OVERFLOW (1'b0)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clear_in       (clear_in),
        .inst_valid     (inst_valid),
        .inst_type      (inst_type),
        .inst_r1        (inst_r1),
        .inst_has_dep1  (inst_has_dep1),
        .inst_dep1      (inst_dep1),
        .inst_r2        (inst_r2),
        .inst_has_dep2  (inst_has_dep2),
        .inst_dep2      (inst_dep2),
        .inst_rob_id    (inst_rob_id),
        .full           (full),
        .cdb_alu_ready  (cdb_alu_ready),
        .cdb_alu_rob_id (cdb_alu_rob_id),
        .cdb_alu_value  (cdb_alu_value),
        .cdb_mem_ready  (cdb_mem_ready),
        .cdb_mem_rob_id (cdb_mem_rob_id),
        .cdb_mem_value  (cdb_mem_value),
        .exe_valid      (exe_valid),
        .exe_type       (exe_type),
        .exe_r1         (exe_r1),
        .exe_r2         (exe_r2),
        .exe_rob_id     (exe_rob_id)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after posedge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic dispatch(input logic [4:0] t, input logic [31:0] r1, input logic hd1,
                            input logic [3:0] d1, input logic [31:0] r2, input logic hd2,
                            input logic [3:0] d2, input logic [3:0] rob);
        inst_valid    = 1'b1;
        inst_type     = t;
        inst_r1       = r1;
        inst_has_dep1 = hd1;
        inst_dep1     = d1;
        inst_r2       = r2;
        inst_has_dep2 = hd2;
        inst_dep2     = d2;
        inst_rob_id   = rob;
        tick();
        inst_valid    = 1'b0;
    endtask

    task automatic alu_bus(input logic en, input logic [3:0] id, input logic [31:0] v);
        cdb_alu_ready  = en;
        cdb_alu_rob_id = id;
        cdb_alu_value  = v;
    endtask

    task automatic mem_bus(input logic en, input logic [3:0] id, input logic [31:0] v);
        cdb_mem_ready  = en;
        cdb_mem_rob_id = id;
        cdb_mem_value  = v;
    endtask

    initial begin
        // ---------------- power-on reset ----------------
        tick(); tick();
        check_eq("por_exe_valid", {31'd0, exe_valid}, 32'd0);
        check_eq("por_full",      {31'd0, full},      32'd0);
        check_eq("por_exe_r1",    exe_r1,             32'd0);
        check_eq("por_exe_rob",   {28'd0, exe_rob_id}, 32'd0);
        rst_in = 1'b1;
        tick();

        // ---------------- 1: reset mid-operation ----------------
        for (int i = 0; i < 3; i++) dispatch(5'd0, 32'd0, 1'b1, 4'd11, 32'd1, 1'b0, 4'd0, 4'(i));
        dispatch(5'd0, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd13);
        tick();
        check_eq("t1_pre_valid", {31'd0, exe_valid}, 32'd1);
        #1 rst_in = 1'b0;
        #1;
        check_eq("t1_rst_valid", {31'd0, exe_valid}, 32'd0);
        check_eq("t1_rst_full",  {31'd0, full},      32'd0);
        tick();
        rst_in = 1'b1;
        alu_bus(1'b1, 4'd11, 32'h55);
        tick();
        alu_bus(1'b0, 4'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t1_no_issue", {31'd0, exe_valid}, 32'd0);
        end

        // ---------------- 2: ADD, no deps ----------------
        dispatch(5'b00000, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3);
        check_eq("t2_lat_valid", {31'd0, exe_valid}, 32'd0);
        tick();
        check_eq("t2_valid", {31'd0, exe_valid},   32'd1);
        check_eq("t2_r1",    exe_r1,               32'd5);
        check_eq("t2_r2",    exe_r2,               32'd7);
        check_eq("t2_rob",   {28'd0, exe_rob_id},  32'd3);
        check_eq("t2_type",  {27'd0, exe_type},    32'd0);
        tick();
        check_eq("t2_once",  {31'd0, exe_valid},   32'd0);

        // ---------------- 3a: SUB, dep1 woken later ----------------
        dispatch(5'b01000, 32'd0, 1'b1, 4'd2, 32'd3, 1'b0, 4'd0, 4'd5);
        tick();
        check_eq("t3a_wait", {31'd0, exe_valid}, 32'd0);
        alu_bus(1'b1, 4'd2, 32'h10);
        tick();
        alu_bus(1'b0, 4'd0, 32'd0);
        check_eq("t3a_wake_edge", {31'd0, exe_valid}, 32'd0);
        tick();
        check_eq("t3a_valid", {31'd0, exe_valid},  32'd1);
        check_eq("t3a_r1",    exe_r1,              32'h10);
        check_eq("t3a_r2",    exe_r2,              32'd3);
        check_eq("t3a_rob",   {28'd0, exe_rob_id}, 32'd5);
        check_eq("t3a_type",  {27'd0, exe_type},   32'h08);

        // ---------------- 3b: SUB, dep1 bypassed at dispatch ----------------
        alu_bus(1'b1, 4'd2, 32'h20);
        dispatch(5'b01000, 32'hDEAD, 1'b1, 4'd2, 32'd4, 1'b0, 4'd0, 4'd6);
        alu_bus(1'b0, 4'd0, 32'd0);
        tick();
        check_eq("t3b_valid", {31'd0, exe_valid},  32'd1);
        check_eq("t3b_r1",    exe_r1,              32'h20);
        check_eq("t3b_rob",   {28'd0, exe_rob_id}, 32'd6);

        // ---------------- 4: fill, overflow, drain in index order ----------------
        for (int i = 0; i < 8; i++) dispatch(5'd1, 32'd0, 1'b1, 4'd9, 32'(i), 1'b0, 4'd0, 4'(i));
        check_eq("t4_full", {31'd0, full}, 32'd1);
        dispatch(5'd2, 32'd99, 1'b0, 4'd0, 32'd99, 1'b0, 4'd0, 4'd15);
        check_eq("t4_full_after_drop", {31'd0, full}, 32'd1);
        check_eq("t4_no_issue", {31'd0, exe_valid}, 32'd0);
        mem_bus(1'b1, 4'd9, 32'h99);
        tick();
        mem_bus(1'b0, 4'd0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("t4_valid", {31'd0, exe_valid},  32'd1);
            check_eq("t4_rob",   {28'd0, exe_rob_id}, 32'(i));
            check_eq("t4_r1",    exe_r1,              32'h99);
            check_eq("t4_r2",    exe_r2,              32'(i));
            if (i == 0) check_eq("t4_not_full", {31'd0, full}, 32'd0);
        end
        tick();
        check_eq("t4_dropped", {31'd0, exe_valid}, 32'd0);

        // ---------------- 5: both buses hit one entry ----------------
        dispatch(5'b10001, 32'd0, 1'b1, 4'd4, 32'd0, 1'b1, 4'd6, 4'd1);
        tick();
        check_eq("t5_wait", {31'd0, exe_valid}, 32'd0);
        alu_bus(1'b1, 4'd4, 32'hAAAA);
        mem_bus(1'b1, 4'd6, 32'hBBBB);
        tick();
        alu_bus(1'b0, 4'd0, 32'd0);
        mem_bus(1'b0, 4'd0, 32'd0);
        check_eq("t5_wake_edge", {31'd0, exe_valid}, 32'd0);
        tick();
        check_eq("t5_valid", {31'd0, exe_valid},  32'd1);
        check_eq("t5_r1",    exe_r1,              32'hAAAA);
        check_eq("t5_r2",    exe_r2,              32'hBBBB);
        check_eq("t5_rob",   {28'd0, exe_rob_id}, 32'd1);
        check_eq("t5_type",  {27'd0, exe_type},   32'h11);

        // ---------------- 6a: clear with busy entries + dispatch ----------------
        for (int i = 0; i < 4; i++) dispatch(5'd0, 32'd0, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 4'(i));
        dispatch(5'd0, 32'd8, 1'b0, 4'd0, 32'd8, 1'b0, 4'd0, 4'd8);
        clear_in = 1'b1;
        dispatch(5'd0, 32'd7, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd7);
        clear_in = 1'b0;
        check_eq("t6_clear_valid", {31'd0, exe_valid}, 32'd0);
        check_eq("t6_clear_full",  {31'd0, full},      32'd0);
        alu_bus(1'b1, 4'd12, 32'h12);
        tick();
        alu_bus(1'b0, 4'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t6_no_issue", {31'd0, exe_valid}, 32'd0);
        end

        // ---------------- 6b: rdy_in stall ----------------
        dispatch(5'd3, 32'h123, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd2);
        dispatch(5'd4, 32'h456, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd3);
        check_eq("t6_pre_stall_rob", {28'd0, exe_rob_id}, 32'd2);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                dispatch(5'd5, 32'h789, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 4'd4);
            end else begin
                tick();
            end
            check_eq("t6_stall_valid", {31'd0, exe_valid},  32'd1);
            check_eq("t6_stall_rob",   {28'd0, exe_rob_id}, 32'd2);
            check_eq("t6_stall_r1",    exe_r1,              32'h123);
            check_eq("t6_stall_type",  {27'd0, exe_type},   32'd3);
        end
        rdy_in = 1'b1;
        tick();
        check_eq("t6_resume_valid", {31'd0, exe_valid},  32'd1);
        check_eq("t6_resume_rob",   {28'd0, exe_rob_id}, 32'd3);
        check_eq("t6_resume_r1",    exe_r1,              32'h456);
        tick();
        check_eq("t6_stall_drop", {31'd0, exe_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
